// File: rtl/pio_write_arb_pkg.sv
// Shared types and constants for the PIO write arbiter.
// Optional readback checking is enabled by defining PIO_WRITE_ARB_READBACK_EN.
package pio_write_arb_pkg;

    localparam int unsigned AVALON_DATA_W = 32;
    localparam logic        IDLE_WRITE_N  = 1'b1;

    // FSM encoding: IDLE -> WRITE -> [READ] -> ACK -> IDLE
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

endpackage

// File: rtl/pio_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module pio_rr_arbiter
    import pio_write_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        cand_idx  = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand     = (32'(ptr) + 32'(off)) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM PIO output register among NUM_REQ requesters.
// Define PIO_WRITE_ARB_READBACK_EN to add a readback-verify cycle after every write.
module pio_write_arbiter
    import pio_write_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic                       pio_chipselect,
    output logic                       pio_write_n,
    output logic [ADDR_W-1:0]          pio_address,
    output logic [AVALON_DATA_W-1:0]   pio_writedata,
    input  logic [AVALON_DATA_W-1:0]   pio_readdata,
    output logic                       rb_mismatch,
    output logic                       rb_err_sticky
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_next;
    logic               gnt_valid;
    logic [IDX_W-1:0]   gnt_idx;
    logic               take;
    logic               busy_next;
    logic               cs_next;
    logic               wn_next;
    logic [NUM_REQ-1:0] ack_next;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    pio_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Winner's payload and the pointer position just past it.
    assign sel_addr = req_addr[32'(gnt_idx) * ADDR_W +: ADDR_W];
    assign sel_data = req_data[32'(gnt_idx) * DATA_W +: DATA_W];
    assign ptr_next = IDX_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);

`ifdef PIO_WRITE_ARB_READBACK_EN
    logic              rb_mis_next;
    logic              rb_bad_c;
    logic [DATA_W-1:0] rb_expect;

    // Only address 0 reads back the written data; everything else must read zero.
    always_comb begin
        rb_expect = (pio_address == '0) ? pio_writedata[DATA_W-1:0] : '0;
        rb_bad_c  = (pio_readdata[DATA_W-1:0] != rb_expect) ||
                    (pio_readdata[AVALON_DATA_W-1:DATA_W] != '0);
    end
`else
    logic unused_readdata;
    assign unused_readdata = ^pio_readdata;
    assign rb_mismatch     = 1'b0;
    assign rb_err_sticky   = 1'b0;
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        cs_next    = 1'b0;
        wn_next    = IDLE_WRITE_N;
        ack_next   = '0;
`ifdef PIO_WRITE_ARB_READBACK_EN
        rb_mis_next = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (gnt_valid) begin
                    state_next = ST_WRITE;
                    take       = 1'b1;
                    cs_next    = 1'b1;
                    wn_next    = ~IDLE_WRITE_N;
                end
            end
            ST_WRITE: begin
`ifdef PIO_WRITE_ARB_READBACK_EN
                state_next = ST_READ;
                cs_next    = 1'b1;
`else
                state_next = ST_ACK;
                ack_next   = NUM_REQ'(1) << last_grant;
`endif
            end
            ST_READ: begin
`ifdef PIO_WRITE_ARB_READBACK_EN
                state_next  = ST_ACK;
                ack_next    = NUM_REQ'(1) << last_grant;
                rb_mis_next = rb_bad_c;
`else
                state_next  = ST_IDLE;
`endif
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    // State, registered outputs and grant latches; reset forces the bus idle immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            busy           <= 1'b0;
            ack            <= '0;
            last_grant     <= '0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= IDLE_WRITE_N;
            pio_address    <= '0;
            pio_writedata  <= '0;
`ifdef PIO_WRITE_ARB_READBACK_EN
            rb_mismatch    <= 1'b0;
            rb_err_sticky  <= 1'b0;
`endif
        end else begin
            state          <= state_next;
            busy           <= busy_next;
            ack            <= ack_next;
            pio_chipselect <= cs_next;
            pio_write_n    <= wn_next;
            if (take) begin
                last_grant    <= gnt_idx;
                ptr           <= ptr_next;
                pio_address   <= sel_addr;
                pio_writedata <= AVALON_DATA_W'(sel_data);
            end
`ifdef PIO_WRITE_ARB_READBACK_EN
            rb_mismatch    <= rb_mis_next;
            rb_err_sticky  <= rb_err_sticky | rb_mis_next;
`endif
        end
    end

endmodule

// File: tb/tb_pio_write_arbiter.sv
// Scoreboard bench for pio_write_arbiter: a transaction-level model predicts each
// grant, bus write and ack; a separate monitor compares them against the DUT.
module tb_pio_write_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 2;
`ifdef PIO_WRITE_ARB_READBACK_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = '0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  last_grant;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [1:0]  pio_address;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;
    logic        rb_mismatch;
    logic        rb_err_sticky;

    always #5 clk = ~clk;

    pio_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .ack            (ack),
        .busy           (busy),
        .last_grant     (last_grant),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_address    (pio_address),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .rb_mismatch    (rb_mismatch),
        .rb_err_sticky  (rb_err_sticky)
    );

    // PIO slave: one data register at address 0, other addresses read zero.
    bit         bad_slave = 1'b0;
    logic [7:0] slave_reg = '0;
    always @(posedge clk)
        if (pio_chipselect && !pio_write_n && pio_address == 2'd0)
            slave_reg <= pio_writedata[7:0];
    assign pio_readdata = (pio_chipselect && pio_address == 2'd0 && !bad_slave) ?
                          {24'h0, slave_reg} : 32'h0;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int         at;
        int         idx;
        logic [1:0] addr;
        logic [7:0] data;
        logic       mism;
    } txn_t;

    txn_t wq[$];
    txn_t aq[$];
    int   n_vec = 0;
    int   n_mis = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Transaction-level reference state.
    int free_at;
    int ptr_m;
    int ack_at[4];
    bit granted[4];
    int n_grants;
    int policy; // 0 drop after ack, 1 hold through ack, 2 random, 3 drain

    function automatic void model_reset();
        free_at = 0;
        ptr_m   = 0;
        for (int i = 0; i < 4; i++) begin
            granted[i] = 1'b0;
            ack_at[i]  = -1;
        end
    endfunction

    function automatic bit any_granted();
        bit a = 1'b0;
        for (int i = 0; i < 4; i++) a |= granted[i];
        return a;
    endfunction

    function automatic void new_req(int i);
        req[i]            = 1'b1;
        req_addr[i*2 +: 2] = ($urandom_range(1, 0) != 0) ? 2'd0 : 2'($urandom_range(3, 0));
        req_data[i*8 +: 8] = 8'($urandom);
    endfunction

    // Predict the grant taken at the coming clock edge from the requests now driven.
    function automatic void model_edge();
        int   e;
        int   g;
        txn_t t;
        e = edge_cnt + 1;
        g = -1;
        if (reset_n && e >= free_at && req != 4'd0) begin
            for (int off = 0; off < 4; off++)
                if (g < 0 && req[(ptr_m + off) % 4]) g = (ptr_m + off) % 4;
            t.at   = e;
            t.idx  = g;
            t.addr = req_addr[g*2 +: 2];
            t.data = req_data[g*8 +: 8];
`ifdef PIO_WRITE_ARB_READBACK_EN
            t.mism = bad_slave && t.addr == 2'd0 && t.data != 8'd0;
`else
            t.mism = 1'b0;
`endif
            wq.push_back(t);
            t.at = e + LAT;
            aq.push_back(t);
            granted[g] = 1'b1;
            ack_at[g]  = e + LAT;
            ptr_m      = (g + 1) % 4;
            free_at    = e + LAT + 2;
            n_grants++;
        end
    endfunction

    // Requester behaviour for the current cycle.
    function automatic void agents();
        for (int i = 0; i < 4; i++) begin
            if (granted[i] && edge_cnt == ack_at[i]) begin
                granted[i] = 1'b0;
                if (policy == 0 || policy == 3) req[i] = 1'b0;
                else if (policy == 2) begin
                    if ($urandom_range(1, 0) != 0) new_req(i);
                    else req[i] = 1'b0;
                end
            end else if (granted[i] && policy == 2) begin
                if ($urandom_range(4, 0) == 0) req[i] = 1'b0;
                if ($urandom_range(4, 0) == 0) req_data[i*8 +: 8] = 8'($urandom);
            end else if (!granted[i] && !req[i] && policy == 2 && $urandom_range(3, 0) == 0) begin
                new_req(i);
            end
        end
    endfunction

    task automatic step();
        agents();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_idle(int maxc);
        int c = 0;
        while ((wq.size() != 0 || aq.size() != 0 || any_granted()) && c < maxc) begin
            step();
            c++;
        end
        chk("drain_in_time", 32'(c < maxc), 32'd1);
        step();
        step();
    endtask

    task automatic set_req(int i, logic [1:0] a, logic [7:0] d);
        req[i]             = 1'b1;
        req_addr[i*2 +: 2] = a;
        req_data[i*8 +: 8] = d;
    endtask

    // Mid-cycle reset: bus must go idle without a clock edge.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("async_cs", 32'(pio_chipselect), 32'd0);
        chk("async_wn", 32'(pio_write_n), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        req = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: compare DUT bus writes and acks against the scoreboard each cycle.
    bit sticky_exp = 1'b0;
    initial begin
        txn_t t;
        bit   exp_w;
        bit   exp_a;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                wq.delete();
                aq.delete();
                sticky_exp = 1'b0;
                chk("rst_cs", 32'(pio_chipselect), 32'd0);
                chk("rst_wn", 32'(pio_write_n), 32'd1);
                chk("rst_ack", 32'(ack), 32'd0);
            end else begin
                exp_w = (wq.size() != 0 && wq[0].at == edge_cnt);
                chk("write_strobe", 32'(pio_chipselect && !pio_write_n), 32'(exp_w));
                if (exp_w) begin
                    t = wq.pop_front();
                    chk("wr_addr", 32'(pio_address), 32'(t.addr));
                    chk("wr_data", pio_writedata, {24'h0, t.data});
                    chk("last_grant", 32'(last_grant), 32'(t.idx));
                    chk("busy_in_write", 32'(busy), 32'd1);
                end
                exp_a = (aq.size() != 0 && aq[0].at == edge_cnt);
                if (exp_a) begin
                    t = aq.pop_front();
                    chk("ack", 32'(ack), 32'(4'b0001 << t.idx));
                    chk("rb_mismatch", 32'(rb_mismatch), 32'(t.mism));
                    sticky_exp |= t.mism;
                end else begin
                    chk("ack_idle", 32'(ack), 32'd0);
                    chk("rb_mismatch_idle", 32'(rb_mismatch), 32'd0);
                end
                chk("rb_err_sticky", 32'(rb_err_sticky), 32'(sticky_exp));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        n_grants = 0;
        policy   = 0;
        // Reset held, then released with no requests: idle for 20 cycles.
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_last_grant", 32'(last_grant), 32'd0);
        repeat (20) begin
            step();
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_cs", 32'(pio_chipselect), 32'd0);
            chk("idle_wn", 32'(pio_write_n), 32'd1);
        end

        // Single request from requester 1.
        set_req(1, 2'd0, 8'hA5);
        run_idle(20);

        // All four held high: rotating grants from a fresh pointer.
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 2'd0, 8'(8'h10 + i));
        policy   = 1;
        n_grants = 0;
        for (int c = 0; c < 40 && n_grants < 5; c++) step();
        chk("five_grants", 32'(n_grants), 32'd5);
        for (int i = 0; i < 4; i++) if (!granted[i]) req[i] = 1'b0;
        policy = 0;
        run_idle(40);

        // Payload changed and request dropped right after grant.
        set_req(2, 2'd0, 8'h3C);
        step();
        req_data[23:16] = 8'hFF;
        req[2]          = 1'b0;
        run_idle(20);

        // Reset during the write cycle, then a clean grant to requester 3.
        set_req(3, 2'd0, 8'h77);
        step();
        do_reset();
        set_req(3, 2'd2, 8'h99);
        run_idle(20);

        // Readback against a faulty slave, then a correct one.
        do_reset();
        bad_slave = 1'b1;
        set_req(0, 2'd0, 8'h5A);
        run_idle(20);
        bad_slave = 1'b0;
        set_req(0, 2'd0, 8'h5A);
        run_idle(20);
        do_reset();
        step();

        // Randomised requester traffic.
        policy = 2;
        repeat (600) step();
        policy = 3;
        run_idle(200);

        chk("scoreboard_empty", 32'(wq.size() + aq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
